// File: rtl/serdesphy_link_seq.sv
// serdesphy_link_seq: bring-up sequencer for the PHY analog datapath.
// Enables the PLL and waits for lock (with retries), settles TX, then enables
// RX/CDR, waits for CDR lock and reports link_ready. Handles lock and supply loss.
module serdesphy_link_seq #(
    parameter int TIMER_W          = 16,
    parameter int PLL_LOCK_TIMEOUT = 2000,
    parameter int CDR_LOCK_TIMEOUT = 4000,
    parameter int SETTLE_TIME      = 16,
    parameter int MAX_RETRY        = 2
) (
    input  logic       clk,
    input  logic       rst_n_in,
    input  logic       por_complete,
    input  logic       power_good,
    input  logic       seq_en,
    input  logic       pll_lock,
    input  logic       cdr_lock,
    input  logic       err_clr,
    output logic       pll_en,
    output logic       tx_en,
    output logic       rx_en,
    output logic       cdr_en,
    output logic       link_ready,
    output logic       seq_busy,
    output logic       seq_error,
    output logic [1:0] err_code,
    output logic [1:0] retry_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PLL_WAIT  = 3'd1;
    localparam logic [2:0] S_PLL_OFF   = 3'd2;
    localparam logic [2:0] S_TX_SETTLE = 3'd3;
    localparam logic [2:0] S_CDR_WAIT  = 3'd4;
    localparam logic [2:0] S_READY     = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;

    localparam logic [1:0] E_NONE     = 2'b00;
    localparam logic [1:0] E_PLL_TMO  = 2'b01;
    localparam logic [1:0] E_CDR_TMO  = 2'b10;
    localparam logic [1:0] E_PLL_LOST = 2'b11;

    localparam logic [TIMER_W-1:0] LP_PLL_TMO   = TIMER_W'(PLL_LOCK_TIMEOUT);
    localparam logic [TIMER_W-1:0] LP_CDR_TMO   = TIMER_W'(CDR_LOCK_TIMEOUT);
    localparam logic [TIMER_W-1:0] LP_SETTLE    = TIMER_W'(SETTLE_TIME);
    localparam logic [TIMER_W-1:0] LP_ONE       = TIMER_W'(1);
    localparam logic [1:0]         LP_MAX_RETRY = 2'(MAX_RETRY);

    logic               r_pll_lock_m, r_pll_lock_s;
    logic               r_cdr_lock_m, r_cdr_lock_s;
    logic [2:0]         r_state, w_state_nxt;
    logic [TIMER_W-1:0] r_timer, w_timer_nxt;
    logic [1:0]         r_retry, w_retry_nxt;
    logic [1:0]         r_err_code, w_err_nxt;
    logic               w_go, w_tmo;
    logic               r_pll_en, r_tx_en, r_rx_en, r_cdr_en;
    logic               r_link_ready, r_seq_busy, r_seq_error;
    logic               w_pll_en, w_tx_en, w_rx_en, w_cdr_en;
    logic               w_link_ready, w_seq_busy, w_seq_error;

    assign w_go  = por_complete & power_good & seq_en;
    assign w_tmo = (r_timer == '0);

    // Two-flop synchronisers for the asynchronous analog lock indicators
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pll_lock_m <= 1'b0;
            r_pll_lock_s <= 1'b0;
            r_cdr_lock_m <= 1'b0;
            r_cdr_lock_s <= 1'b0;
        end else begin
            r_pll_lock_m <= pll_lock;
            r_pll_lock_s <= r_pll_lock_m;
            r_cdr_lock_m <= cdr_lock;
            r_cdr_lock_s <= r_cdr_lock_m;
        end
    end

    // Next-state, timer, retry and error-code decisions; abort outranks everything
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_retry_nxt = r_retry;
        w_err_nxt   = r_err_code;
        if ((r_state != S_IDLE) && !w_go) begin
            w_state_nxt = S_IDLE;
            w_retry_nxt = 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (err_clr) w_err_nxt = E_NONE;
                    if (w_go) begin
                        w_state_nxt = S_PLL_WAIT;
                        w_retry_nxt = 2'b00;
                        w_timer_nxt = LP_PLL_TMO;
                    end
                end
                S_PLL_WAIT: begin
                    if (r_pll_lock_s) begin
                        w_state_nxt = S_TX_SETTLE;
                        w_timer_nxt = LP_SETTLE;
                    end else if (w_tmo) begin
                        if (r_retry < LP_MAX_RETRY) begin
                            w_state_nxt = S_PLL_OFF;
                            w_retry_nxt = r_retry + 2'b01;
                            w_timer_nxt = LP_SETTLE;
                        end else begin
                            w_state_nxt = S_ERROR;
                            w_err_nxt   = E_PLL_TMO;
                        end
                    end else begin
                        w_timer_nxt = r_timer - LP_ONE;
                    end
                end
                S_PLL_OFF: begin
                    if (w_tmo) begin
                        w_state_nxt = S_PLL_WAIT;
                        w_timer_nxt = LP_PLL_TMO;
                    end else begin
                        w_timer_nxt = r_timer - LP_ONE;
                    end
                end
                S_TX_SETTLE: begin
                    if (!r_pll_lock_s) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = E_PLL_LOST;
                    end else if (w_tmo) begin
                        w_state_nxt = S_CDR_WAIT;
                        w_timer_nxt = LP_CDR_TMO;
                    end else begin
                        w_timer_nxt = r_timer - LP_ONE;
                    end
                end
                S_CDR_WAIT: begin
                    if (!r_pll_lock_s) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = E_PLL_LOST;
                    end else if (r_cdr_lock_s) begin
                        w_state_nxt = S_READY;
                    end else if (w_tmo) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = E_CDR_TMO;
                    end else begin
                        w_timer_nxt = r_timer - LP_ONE;
                    end
                end
                S_READY: begin
                    if (!r_pll_lock_s) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = E_PLL_LOST;
                    end else if (!r_cdr_lock_s) begin
                        w_state_nxt = S_CDR_WAIT;
                        w_timer_nxt = LP_CDR_TMO;
                    end
                end
                S_ERROR: begin
                    if (err_clr) begin
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = E_NONE;
                        w_retry_nxt = 2'b00;
                    end
                end
                default: w_state_nxt = S_ERROR;
            endcase
        end
    end

    // Output levels decoded from the next state so they register together with it
    always_comb begin
        w_pll_en     = 1'b0;
        w_tx_en      = 1'b0;
        w_rx_en      = 1'b0;
        w_cdr_en     = 1'b0;
        w_link_ready = 1'b0;
        w_seq_busy   = 1'b0;
        w_seq_error  = 1'b0;
        case (w_state_nxt)
            S_PLL_WAIT:  begin w_pll_en = 1'b1; w_seq_busy = 1'b1; end
            S_PLL_OFF:   w_seq_busy = 1'b1;
            S_TX_SETTLE: begin w_pll_en = 1'b1; w_tx_en = 1'b1; w_seq_busy = 1'b1; end
            S_CDR_WAIT:  begin
                w_pll_en = 1'b1; w_tx_en = 1'b1; w_rx_en = 1'b1; w_cdr_en = 1'b1;
                w_seq_busy = 1'b1;
            end
            S_READY:     begin
                w_pll_en = 1'b1; w_tx_en = 1'b1; w_rx_en = 1'b1; w_cdr_en = 1'b1;
                w_link_ready = 1'b1;
            end
            S_ERROR:     w_seq_error = 1'b1;
            default:     w_seq_busy = 1'b0;
        endcase
    end

    // Sequencer state, shared timer and all registered outputs
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_retry      <= 2'b00;
            r_err_code   <= E_NONE;
            r_pll_en     <= 1'b0;
            r_tx_en      <= 1'b0;
            r_rx_en      <= 1'b0;
            r_cdr_en     <= 1'b0;
            r_link_ready <= 1'b0;
            r_seq_busy   <= 1'b0;
            r_seq_error  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_retry      <= w_retry_nxt;
            r_err_code   <= w_err_nxt;
            r_pll_en     <= w_pll_en;
            r_tx_en      <= w_tx_en;
            r_rx_en      <= w_rx_en;
            r_cdr_en     <= w_cdr_en;
            r_link_ready <= w_link_ready;
            r_seq_busy   <= w_seq_busy;
            r_seq_error  <= w_seq_error;
        end
    end

    assign pll_en     = r_pll_en;
    assign tx_en      = r_tx_en;
    assign rx_en      = r_rx_en;
    assign cdr_en     = r_cdr_en;
    assign link_ready = r_link_ready;
    assign seq_busy   = r_seq_busy;
    assign seq_error  = r_seq_error;
    assign err_code   = r_err_code;
    assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_serdesphy_link_seq.sv
// tb_serdesphy_link_seq: directed bench for the PHY bring-up sequencer with a
// phase-level reference model compared on every falling clock edge.
module tb_serdesphy_link_seq;

    localparam int PLL_TMO = 8;
    localparam int CDR_TMO = 8;
    localparam int SETTLE  = 4;
    localparam int MAXR    = 1;

    localparam int SIG_PLL = 0, SIG_TX = 1, SIG_RX = 2, SIG_CDR = 3;
    localparam int SIG_RDY = 4, SIG_BUSY = 5, SIG_ERR = 6, SIG_RETRY0 = 7;

    // model phases
    localparam int P_IDLE = 0, P_PLLW = 1, P_OFF = 2, P_TXS = 3;
    localparam int P_CDRW = 4, P_RDY = 5, P_ERR = 6;

    logic       clk = 1'b0;
    logic       rst_n_in;
    logic       por_complete, power_good, seq_en, pll_lock, cdr_lock, err_clr;
    logic       pll_en, tx_en, rx_en, cdr_en, link_ready, seq_busy, seq_error;
    logic [1:0] err_code, retry_cnt;

    int n_chk = 0;
    int n_err = 0;

    serdesphy_link_seq #(
        .TIMER_W(16), .PLL_LOCK_TIMEOUT(PLL_TMO), .CDR_LOCK_TIMEOUT(CDR_TMO),
        .SETTLE_TIME(SETTLE), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .rst_n_in(rst_n_in), .por_complete(por_complete),
        .power_good(power_good), .seq_en(seq_en), .pll_lock(pll_lock),
        .cdr_lock(cdr_lock), .err_clr(err_clr), .pll_en(pll_en), .tx_en(tx_en),
        .rx_en(rx_en), .cdr_en(cdr_en), .link_ready(link_ready),
        .seq_busy(seq_busy), .seq_error(seq_error), .err_code(err_code),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_ph, m_cnt, m_tries, m_err;
    bit m_p1, m_p2, m_c1, m_c2;

    task automatic m_enter(input int ph);
        m_ph  = ph;
        m_cnt = 0;
    endtask

    task automatic m_reset();
        m_ph = P_IDLE; m_cnt = 0; m_tries = 0; m_err = 0;
        m_p1 = 0; m_p2 = 0; m_c1 = 0; m_c2 = 0;
    endtask

    task automatic m_step();
        bit ps, cs, go;
        ps = m_p2; cs = m_c2;
        m_p2 = m_p1; m_p1 = pll_lock;
        m_c2 = m_c1; m_c1 = cdr_lock;
        go = por_complete && power_good && seq_en;
        m_cnt++;
        if (m_ph != P_IDLE && !go) begin
            m_enter(P_IDLE);
            m_tries = 0;
        end else begin
            case (m_ph)
                P_IDLE: begin
                    if (err_clr) m_err = 0;
                    if (go) begin m_enter(P_PLLW); m_tries = 0; end
                end
                P_PLLW: begin
                    if (ps) m_enter(P_TXS);
                    else if (m_cnt == PLL_TMO + 1) begin
                        if (m_tries < MAXR) begin m_enter(P_OFF); m_tries++; end
                        else begin m_enter(P_ERR); m_err = 1; end
                    end
                end
                P_OFF: if (m_cnt == SETTLE + 1) m_enter(P_PLLW);
                P_TXS: begin
                    if (!ps) begin m_enter(P_ERR); m_err = 3; end
                    else if (m_cnt == SETTLE + 1) m_enter(P_CDRW);
                end
                P_CDRW: begin
                    if (!ps) begin m_enter(P_ERR); m_err = 3; end
                    else if (cs) m_enter(P_RDY);
                    else if (m_cnt == CDR_TMO + 1) begin m_enter(P_ERR); m_err = 2; end
                end
                P_RDY: begin
                    if (!ps) begin m_enter(P_ERR); m_err = 3; end
                    else if (!cs) m_enter(P_CDRW);
                end
                P_ERR: if (err_clr) begin m_enter(P_IDLE); m_err = 0; m_tries = 0; end
                default: m_enter(P_ERR);
            endcase
        end
    endtask

    function automatic logic [10:0] model_vec();
        logic pe, te, re, ce, lr, bz, er;
        pe = (m_ph == P_PLLW) || (m_ph == P_TXS) || (m_ph == P_CDRW) || (m_ph == P_RDY);
        te = (m_ph == P_TXS) || (m_ph == P_CDRW) || (m_ph == P_RDY);
        re = (m_ph == P_CDRW) || (m_ph == P_RDY);
        ce = re;
        lr = (m_ph == P_RDY);
        bz = (m_ph == P_PLLW) || (m_ph == P_OFF) || (m_ph == P_TXS) || (m_ph == P_CDRW);
        er = (m_ph == P_ERR);
        return {pe, te, re, ce, lr, bz, er, 2'(m_err), 2'(m_tries)};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {pll_en, tx_en, rx_en, cdr_en, link_ready, seq_busy, seq_error,
                err_code, retry_cnt};
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n_in);
            if (!rst_n_in) m_reset();
            else m_step();
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("model_cmp", {21'b0, dut_vec()}, {21'b0, model_vec()});
        end
    end

    function automatic logic sig(input int idx);
        case (idx)
            SIG_PLL:    return pll_en;
            SIG_TX:     return tx_en;
            SIG_RX:     return rx_en;
            SIG_CDR:    return cdr_en;
            SIG_RDY:    return link_ready;
            SIG_BUSY:   return seq_busy;
            SIG_ERR:    return seq_error;
            SIG_RETRY0: return retry_cnt[0];
            default:    return 1'b0;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // edges until sig(idx)==val; -1 if the budget expires
    task automatic wait_sig(input int idx, input logic val, input int max, output int n);
        n = 0;
        forever begin
            @(posedge clk); #1; n++;
            if (sig(idx) === val) break;
            if (n >= max) begin
                n_chk++; n_err++;
                $display("FAIL wait_sig%0d: level %0b not seen in %0d cycles", idx, val, max);
                n = -1;
                break;
            end
        end
    endtask

    // edges for which sig(idx) keeps value val
    task automatic run_len(input int idx, input logic val, input int max, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (sig(idx) === val && n < max);
    endtask

    // ---------------- directed stimulus ----------------
    int n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in = 1'b0;
        por_complete = 1'b0; power_good = 1'b0; seq_en = 1'b0;
        pll_lock = 1'b0; cdr_lock = 1'b0; err_clr = 1'b0;
        tick(3);
        chk("reset_outputs", {21'b0, dut_vec()}, 32'd0);
        rst_n_in = 1'b1;
        tick(2);

        // 1: nominal bring-up
        por_complete = 1'b1; power_good = 1'b1; seq_en = 1'b1;
        wait_sig(SIG_PLL, 1'b1, 10, n);
        chk("t1_pll_en_latency", n, 1);
        tick(4);
        pll_lock = 1'b1;
        wait_sig(SIG_TX, 1'b1, 20, n);
        chk("t1_tx_after_lock", n, 3);
        wait_sig(SIG_RX, 1'b1, 20, n);
        chk("t1_rx_after_tx", n, 5);
        chk("t1_cdr_en", cdr_en, 1);
        cdr_lock = 1'b1;
        wait_sig(SIG_RDY, 1'b1, 20, n);
        chk("t1_ready_after_cdr", n, 3);
        chk("t1_err_code", err_code, 0);
        chk("t1_busy_in_ready", seq_busy, 0);

        // 4: CDR lock blip, then PLL loss in READY
        cdr_lock = 1'b0;
        wait_sig(SIG_RDY, 1'b0, 20, n);
        chk("t4_ready_drop", n, 3);
        chk("t4_enables_kept", {pll_en, tx_en, rx_en, cdr_en}, 4'hF);
        tick(1);
        cdr_lock = 1'b1;
        wait_sig(SIG_RDY, 1'b1, 20, n);
        chk("t4_ready_back", n, 3);
        pll_lock = 1'b0;
        wait_sig(SIG_RDY, 1'b0, 20, n);
        chk("t4_pll_loss_lat", n, 3);
        chk("t4_err_code", err_code, 3);
        chk("t4_seq_error", seq_error, 1);
        chk("t4_enables_off", {pll_en, tx_en, rx_en, cdr_en}, 4'h0);
        seq_en = 1'b0; err_clr = 1'b1;
        tick(1);
        chk("t4_abort_keeps_err", err_code, 3);
        chk("t4_abort_to_idle", seq_error, 0);
        tick(1);
        chk("t4_clr_in_idle", err_code, 0);
        err_clr = 1'b0; cdr_lock = 1'b0;
        tick(3);

        // 2: PLL never locks -> retry then error
        seq_en = 1'b1;
        wait_sig(SIG_PLL, 1'b1, 10, n);
        chk("t2_start", n, 1);
        run_len(SIG_PLL, 1'b1, 40, n);
        chk("t2_first_high", n, 9);
        run_len(SIG_PLL, 1'b0, 40, n);
        chk("t2_low_gap", n, 5);
        run_len(SIG_PLL, 1'b1, 40, n);
        chk("t2_second_high", n, 9);
        chk("t2_seq_error", seq_error, 1);
        chk("t2_err_code", err_code, 1);
        chk("t2_retry_cnt", retry_cnt, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t2_clr_idle", {seq_error, pll_en, seq_busy}, 3'b000);
        chk("t2_clr_code", err_code, 0);
        chk("t2_clr_retry", retry_cnt, 0);
        tick(1);
        chk("t2_restart", pll_en, 1);
        seq_en = 1'b0;
        tick(1);
        chk("t2_abort", pll_en, 0);

        // 3: PLL locks, CDR never does
        pll_lock = 1'b1;
        tick(3);
        seq_en = 1'b1;
        wait_sig(SIG_CDR, 1'b1, 30, n);
        chk("t3_cdr_en_latency", n, 7);
        run_len(SIG_CDR, 1'b1, 30, n);
        chk("t3_cdr_dwell", n, 9);
        chk("t3_err_code", err_code, 2);
        chk("t3_seq_error", seq_error, 1);
        chk("t3_enables_off", {pll_en, tx_en, rx_en, cdr_en}, 4'h0);
        seq_en = 1'b0; err_clr = 1'b1;
        tick(1);
        chk("t3_abort_wins", err_code, 2);
        tick(1);
        err_clr = 1'b0;
        chk("t3_cleared", err_code, 0);

        // 5: supply loss mid PLL_WAIT after a retry
        pll_lock = 1'b0;
        tick(3);
        seq_en = 1'b1;
        wait_sig(SIG_RETRY0, 1'b1, 30, n);
        wait_sig(SIG_PLL, 1'b1, 20, n);
        tick(3);
        power_good = 1'b0;
        tick(1);
        chk("t5_all_zero", {21'b0, dut_vec()}, 32'd0);
        power_good = 1'b1;
        wait_sig(SIG_PLL, 1'b1, 10, n);
        chk("t5_restart_lat", n, 1);
        chk("t5_retry_clear", retry_cnt, 0);
        seq_en = 1'b0;
        tick(1);

        // 6: asynchronous reset in CDR_WAIT
        pll_lock = 1'b1;
        tick(3);
        seq_en = 1'b1;
        wait_sig(SIG_CDR, 1'b1, 30, n);
        chk("t6_reach_cdr_wait", n, 7);
        tick(2);
        #2 rst_n_in = 1'b0;
        #1 chk("t6_async_zero", {21'b0, dut_vec()}, 32'd0);
        tick(2);
        rst_n_in = 1'b1;
        cdr_lock = 1'b1;
        wait_sig(SIG_RDY, 1'b1, 40, n);
        chk("t6_ready_after_reset", link_ready, 1);
        chk("t6_err_code", err_code, 0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
